// File: rtl/mux5_sel_sequencer_pkg.sv
// mux5_pkg: shared constants, state encoding and the expected-bit helper
// for the 5:1 mux select sequencer.
//   N_CH      number of mux channels (fixed at 5)
//   SEL_W     select width
//   LAST_SEL  final select value of a frame
//   CNT_W     dwell counter width
package mux5_pkg;

    localparam int                N_CH     = 5;
    localparam int                SEL_W    = 3;
    localparam logic [SEL_W-1:0]  LAST_SEL = 3'd4;
    localparam int                CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_e;

    // Bit of the driven word that the mux should return for select s.
    // Selects 5..7 are never driven; they map to 0.
    function automatic logic sel_bit(input logic [N_CH-1:0] w,
                                     input logic [SEL_W-1:0] s);
        logic b;
        case (s)
            3'd0:    b = w[0];
            3'd1:    b = w[1];
            3'd2:    b = w[2];
            3'd3:    b = w[3];
            3'd4:    b = w[4];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mux5_sel_sequencer_if.sv
// mux5_sel_sequencer_if: bundles the load port, the mux drive/return path,
// the serial output stream and status flags.
//   master : the sequencer (drives load_ready, mux_i/mux_s, ser_*, busy, err)
//   slave  : the environment (drives load_valid/data, mux_y, ser_ready)
import mux5_pkg::*;

interface mux5_sel_sequencer_if;
    logic                  load_valid;
    logic                  load_ready;
    logic [N_CH-1:0]       load_data;
    logic [N_CH-1:0]       mux_i;
    logic [SEL_W-1:0]      mux_s;
    logic                  mux_y;
    logic                  ser_valid;
    logic                  ser_ready;
    logic                  ser_bit;
    logic                  ser_last;
    logic                  busy;
    logic                  err;

    modport master (
        input  load_valid, load_data, mux_y, ser_ready,
        output load_ready, mux_i, mux_s, ser_valid, ser_bit, ser_last, busy, err
    );

    modport slave (
        output load_valid, load_data, mux_y, ser_ready,
        input  load_ready, mux_i, mux_s, ser_valid, ser_bit, ser_last, busy, err
    );
endinterface

// File: rtl/mux5_dwell_timer.sv
// mux5_dwell_timer: loadable 4-bit down-counter with a zero flag.
// Counts down by one per cycle and parks at zero.
//   clk, rst  clock and synchronous active-high reset
//   load      load load_val this cycle (wins over counting)
//   load_val  value to load
//   zero      counter currently at zero
import mux5_pkg::*;

module mux5_dwell_timer (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/mux5_sel_sequencer.sv
// mux5_sel_sequencer: drives a 5-bit word onto a 5:1 mux, walks the select
// through 0..4 holding each for DWELL cycles, samples the mux output and
// streams the samples out LSB-index first over valid/ready. err is a sticky
// flag raised when a sample disagrees with the driven bit.
//   clk, rst  clock and synchronous active-high reset
//   bus       mux5_sel_sequencer_if.master (load, mux, serial and status)
//   DWELL     settle cycles per select, 1..15
import mux5_pkg::*;

module mux5_sel_sequencer #(
    parameter int DWELL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mux5_sel_sequencer_if.master  bus
);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);

    state_e state;
    logic   tmr_load;
    logic   tmr_zero;
    logic   exp_bit;

    // load_ready is the only combinational output; a word is never taken
    // while a frame runs, so there is no accept overlap.
    assign bus.load_ready = (state == IDLE);

    // Reload the dwell on accept and on every non-final handshake.
    assign tmr_load = ((state == IDLE) && bus.load_valid) ||
                      ((state == PRESENT) && bus.ser_ready && !bus.ser_last);

    assign exp_bit = sel_bit(bus.mux_i, bus.mux_s);

    mux5_dwell_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (DWELL_LD),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.mux_i     <= '0;
            bus.mux_s     <= '0;
            bus.ser_valid <= 1'b0;
            bus.ser_bit   <= 1'b0;
            bus.ser_last  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        bus.mux_i <= bus.load_data;
                        bus.mux_s <= '0;
                        bus.busy  <= 1'b1;
                        bus.err   <= 1'b0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        bus.ser_bit   <= bus.mux_y;
                        bus.ser_valid <= 1'b1;
                        bus.ser_last  <= (bus.mux_s == LAST_SEL);
                        bus.err       <= bus.err | (bus.mux_y != exp_bit);
                        state         <= PRESENT;
                    end
                end
                PRESENT: begin
                    // ser_valid is always high here, so ready alone completes
                    // the handshake; otherwise everything holds.
                    if (bus.ser_ready) begin
                        bus.ser_valid <= 1'b0;
                        if (bus.ser_last) begin
                            bus.mux_s <= '0;
                            bus.busy  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            bus.mux_s <= bus.mux_s + 1'b1;
                            state     <= SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux5_sel_sequencer.sv
// Directed bench for mux5_sel_sequencer: a DWELL=1 instance with a 2:1-tree
// mux model (optionally faulted on one select) and a DWELL=4 instance.
import mux5_pkg::*;

module tb_mux5_sel_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic fault_en;
    logic [2:0] fault_sel;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux5_sel_sequencer_if if1 ();
    mux5_sel_sequencer_if if4 ();

    mux5_sel_sequencer #(.DWELL(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1.master));
    mux5_sel_sequencer #(.DWELL(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4.master));

    // 5:1 mux built from 2:1 stages
    function automatic logic mux_model(input logic [4:0] i, input logic [2:0] s);
        logic m01, m23, m03;
        m01 = s[0] ? i[1] : i[0];
        m23 = s[0] ? i[3] : i[2];
        m03 = s[1] ? m23 : m01;
        return s[2] ? i[4] : m03;
    endfunction

    assign if1.mux_y = mux_model(if1.mux_i, if1.mux_s) ^ (fault_en && (if1.mux_s == fault_sel));
    assign if4.mux_y = mux_model(if4.mux_i, if4.mux_s);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the negedge right after the accept edge. Collects five bits
    // (optionally stalling ready on one bit) and returns the number of edges
    // until and including the final handshake.
    task automatic collect(input int stall_bit, input int stall_n, input logic [4:0] w,
                           output logic [4:0] bits, output logic [4:0] lasts,
                           output logic [4:0] errs, output logic [14:0] sels,
                           output int n, output logic rdy_seen);
        int idx = 0;
        int stalled = 0;
        bits = '0; lasts = '0; errs = '0; sels = '0; n = 0; rdy_seen = 1'b0;
        while (idx < 5 && n < 200) begin
            rdy_seen |= if1.load_ready;
            if (if1.ser_valid && idx == stall_bit && stalled < stall_n) begin
                if1.ser_ready = 1'b0;
                stalled++;
                chk("stall_bit", 32'(if1.ser_bit), 32'(w[stall_bit]));
                chk("stall_sel", 32'(if1.mux_s), 32'(stall_bit));
            end else begin
                if1.ser_ready = 1'b1;
                if (if1.ser_valid) begin
                    bits[idx]       = if1.ser_bit;
                    lasts[idx]      = if1.ser_last;
                    errs[idx]       = if1.err;
                    sels[idx*3 +: 3] = if1.mux_s;
                    idx++;
                end
            end
            @(negedge clk);
            n++;
        end
        if (idx < 5) chk("timeout", 32'(idx), 32'd5);
    endtask

    task automatic start_load(input logic [4:0] w);
        if1.load_valid = 1'b1;
        if1.load_data  = w;
        @(negedge clk);
        if1.load_valid = 1'b0;
    endtask

    localparam logic [14:0] SEL_SEQ = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  bits, lasts, errs;
        logic [14:0] sels;
        int          n;
        logic        rdy;
        int          tv[5];
        int          tsel2, idx, guard;

        rst = 1'b1; fault_en = 1'b0; fault_sel = 3'd3;
        if1.load_valid = 1'b0; if1.load_data = '0; if1.ser_ready = 1'b1;
        if4.load_valid = 1'b0; if4.load_data = '0; if4.ser_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mux_i",  32'(if1.mux_i), 32'd0);
        chk("rst_mux_s",  32'(if1.mux_s), 32'd0);
        chk("rst_valid",  32'(if1.ser_valid), 32'd0);
        chk("rst_bit",    32'(if1.ser_bit), 32'd0);
        chk("rst_last",   32'(if1.ser_last), 32'd0);
        chk("rst_busy",   32'(if1.busy), 32'd0);
        chk("rst_err",    32'(if1.err), 32'd0);
        chk("rst_ready",  32'(if1.load_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // nominal frame
        start_load(5'b10001);
        chk("nom_busy", 32'(if1.busy), 32'd1);
        collect(-1, 0, 5'b10001, bits, lasts, errs, sels, n, rdy);
        chk("nom_bits",  32'(bits), 32'b10001);
        chk("nom_last",  32'(lasts), 32'b10000);
        chk("nom_sels",  32'(sels), 32'(SEL_SEQ));
        chk("nom_errs",  32'(errs), 32'd0);
        chk("nom_len",   32'(n), 32'd10);
        chk("nom_rdy",   32'(rdy), 32'd0);
        chk("nom_busy0", 32'(if1.busy), 32'd0);
        chk("nom_ldrdy", 32'(if1.load_ready), 32'd1);

        // backpressure on bit 2
        start_load(5'b01010);
        collect(2, 3, 5'b01010, bits, lasts, errs, sels, n, rdy);
        chk("bp_bits", 32'(bits), 32'b01010);
        chk("bp_last", 32'(lasts), 32'b10000);
        chk("bp_len",  32'(n), 32'd13);

        // fault on select 3
        fault_en = 1'b1; fault_sel = 3'd3;
        start_load(5'b11111);
        collect(-1, 0, 5'b11111, bits, lasts, errs, sels, n, rdy);
        chk("flt_bits", 32'(bits), 32'b10111);
        chk("flt_errs", 32'(errs), 32'b11000);
        repeat (2) @(negedge clk);
        chk("flt_err_idle", 32'(if1.err), 32'd1);
        chk("flt_busy",     32'(if1.busy), 32'd0);
        fault_en = 1'b0;

        // busy rejection; this load also clears err
        if1.load_valid = 1'b1; if1.load_data = 5'b11000;
        @(negedge clk);
        chk("clr_err",   32'(if1.err), 32'd0);
        chk("rej_mux_i", 32'(if1.mux_i), 32'b11000);
        if1.load_data = 5'b00111;
        collect(-1, 0, 5'b11000, bits, lasts, errs, sels, n, rdy);
        chk("rej_bits",  32'(bits), 32'b11000);
        chk("rej_rdy",   32'(rdy), 32'd0);
        chk("rej_len",   32'(n), 32'd10);
        chk("rej_mux_hold", 32'(if1.mux_i), 32'b11000);
        chk("rej_ldrdy", 32'(if1.load_ready), 32'd1);
        @(negedge clk);
        if1.load_valid = 1'b0;
        chk("acc_busy",  32'(if1.busy), 32'd1);
        chk("acc_mux_i", 32'(if1.mux_i), 32'b00111);
        collect(-1, 0, 5'b00111, bits, lasts, errs, sels, n, rdy);
        chk("acc_bits",  32'(bits), 32'b00111);
        chk("acc_len",   32'(n), 32'd10);

        // mid-frame reset while bit 2 is presented; err set by select 1 first
        fault_en = 1'b1; fault_sel = 3'd1;
        start_load(5'b10101);
        guard = 0;
        while (!(if1.ser_valid && if1.mux_s == 3'd2) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        chk("mr_reach", 32'(guard < 30), 32'd1);
        chk("mr_err_pre",  32'(if1.err), 32'd1);
        chk("mr_last_pre", 32'(if1.ser_last), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fault_en = 1'b0;
        chk("mr_valid", 32'(if1.ser_valid), 32'd0);
        chk("mr_busy",  32'(if1.busy), 32'd0);
        chk("mr_mux_s", 32'(if1.mux_s), 32'd0);
        chk("mr_mux_i", 32'(if1.mux_i), 32'd0);
        chk("mr_err",   32'(if1.err), 32'd0);
        chk("mr_ldrdy", 32'(if1.load_ready), 32'd1);
        chk("mr_last",  32'(if1.ser_last), 32'd0);
        repeat (3) @(negedge clk);
        chk("mr_quiet", 32'(if1.ser_valid | if1.ser_last), 32'd0);

        // DWELL=4 instance
        if4.load_valid = 1'b1; if4.load_data = 5'b00100;
        @(negedge clk);
        if4.load_valid = 1'b0;
        n = 0; idx = 0; tsel2 = -1; bits = '0;
        for (int k = 0; k < 5; k++) tv[k] = 0;
        while (idx < 5 && n < 200) begin
            if (if4.mux_s == 3'd2 && tsel2 < 0) tsel2 = n;
            if (if4.ser_valid) begin
                tv[idx]   = n;
                bits[idx] = if4.ser_bit;
                idx++;
            end
            @(negedge clk);
            n++;
        end
        chk("d4_count", 32'(idx), 32'd5);
        chk("d4_first", 32'(tv[0]), 32'd4);
        for (int k = 1; k < 5; k++) chk("d4_gap", 32'(tv[k] - tv[k-1]), 32'd5);
        chk("d4_sel2_to_bit2", 32'(tv[2] - tsel2), 32'd4);
        chk("d4_bits", 32'(bits), 32'b00100);
        chk("d4_len",  32'(n), 32'd25);
        chk("d4_busy", 32'(if4.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
